// File: rtl/register_bus_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// register_bus_scheduler_pkg
// Shared definitions for the register bus scheduler:
//   - default sizing for requesters, registers and register index width
//   - FSM state encoding (IDLE=0, DRIVE=1, LATCH=2, RELEASE=3)
//   - rr_next(): round-robin successor of a requester index
// ----------------------------------------------------------------------------
package register_bus_scheduler_pkg;

    localparam int unsigned DefNrOfReq  = 4;
    localparam int unsigned DefNrOfRegs = 8;
    localparam int unsigned DefSelBits  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        LATCH   = 2'd2,
        RELEASE = 2'd3
    } sched_state_e;

    // Requester that follows idx, wrapping n-1 -> 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/register_bus_scheduler_if.sv
// ----------------------------------------------------------------------------
// register_bus_scheduler_if
// Bundles the requester handshake and the register-bus control lines.
//   req   : per-requester transfer request (level, held until granted)
//   src   : per-requester source register index, slice i = requester i
//   dst   : per-requester destination register index
//   grant : one-hot, one-cycle pulse when a request is accepted
//   cs    : per-register output disable (1 = high-Z, 0 = drives the bus)
//   ld    : per-register load enable
//   busy  : scheduler is not idle
//   done  : one-cycle pulse when a transfer completes
// Modports:
//   master : the scheduler side (drives grant/cs/ld/busy/done)
//   slave  : the requester/register side (drives req/src/dst)
// ----------------------------------------------------------------------------
interface register_bus_scheduler_if
    import register_bus_scheduler_pkg::*;
#(
    parameter int unsigned NrOfReq  = DefNrOfReq,
    parameter int unsigned NrOfRegs = DefNrOfRegs,
    parameter int unsigned SelBits  = DefSelBits
) ();

    logic [NrOfReq-1:0]         req;
    logic [NrOfReq*SelBits-1:0] src;
    logic [NrOfReq*SelBits-1:0] dst;
    logic [NrOfReq-1:0]         grant;
    logic [NrOfRegs-1:0]        cs;
    logic [NrOfRegs-1:0]        ld;
    logic                       busy;
    logic                       done;

    modport master (
        input  req,
        input  src,
        input  dst,
        output grant,
        output cs,
        output ld,
        output busy,
        output done
    );

    modport slave (
        output req,
        output src,
        output dst,
        input  grant,
        input  cs,
        input  ld,
        input  busy,
        input  done
    );

endinterface

// File: rtl/register_bus_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Searches req starting at ptr and
// wrapping NrOfReq-1 -> 0; the first set request wins.
//   req_i : request vector
//   ptr_i : requester index where the search starts
//   en_i  : when 0 no grant is produced
//   gnt_o : one-hot grant (all zero if nothing requested or disabled)
//   idx_o : index of the granted requester (0 when gnt_o is zero)
// ----------------------------------------------------------------------------
module rr_arbiter
    import register_bus_scheduler_pkg::*;
#(
    parameter int unsigned NrOfReq = DefNrOfReq,
    parameter int unsigned IdxW    = (NrOfReq > 1) ? $clog2(NrOfReq) : 1
) (
    input  logic [NrOfReq-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NrOfReq-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = 0;
        found = 1'b0;
        if (en_i) begin
            for (int unsigned off = 0; off < NrOfReq; off++) begin
                // ptr_i is always < NrOfReq, so a single subtract wraps it.
                cand = 32'(ptr_i) + off;
                if (cand >= NrOfReq) begin
                    cand = cand - NrOfReq;
                end
                if (!found && req_i[cand]) begin
                    found       = 1'b1;
                    gnt_o[cand] = 1'b1;
                    idx_o       = IdxW'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/register_bus_scheduler.sv
// ----------------------------------------------------------------------------
// register_bus_scheduler
// Moves one register's value to another over a shared tri-state bus.
// A transfer runs IDLE -> DRIVE -> LATCH -> RELEASE -> IDLE, one step per
// Tick, with break-before-make between transfers.
//   Clock : single clock, rising edge
//   Reset : asynchronous, active-low
//   Tick  : advance enable; the FSM and cs/ld only change on Tick=1 edges
//   bus   : requester handshake and register bus controls (master modport)
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module register_bus_scheduler
    import register_bus_scheduler_pkg::*;
#(
    parameter int unsigned NrOfReq  = DefNrOfReq,
    parameter int unsigned NrOfRegs = DefNrOfRegs,
    parameter int unsigned SelBits  = DefSelBits
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Tick,
    register_bus_scheduler_if.master   bus
);

    localparam int unsigned IdxW = (NrOfReq > 1) ? $clog2(NrOfReq) : 1;

    sched_state_e         state_q, state_d;
    logic [IdxW-1:0]      ptr_q,   ptr_d;
    logic [SelBits-1:0]   src_q,   src_d;
    logic [SelBits-1:0]   dst_q,   dst_d;
    logic [NrOfReq-1:0]   grant_q, grant_d;
    logic [NrOfRegs-1:0]  cs_q,    cs_d;
    logic [NrOfRegs-1:0]  ld_q,    ld_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic                 arb_en;
    logic [NrOfReq-1:0]   arb_gnt;
    logic [IdxW-1:0]      arb_idx;

    // One-hot decode of a register index; indices >= NrOfRegs select nothing.
    function automatic logic [NrOfRegs-1:0] sel_onehot(input logic [SelBits-1:0] idx);
        logic [NrOfRegs-1:0] v;
        v = '0;
        for (int unsigned r = 0; r < NrOfRegs; r++) begin
            if (32'(idx) == r) begin
                v[r] = 1'b1;
            end
        end
        return v;
    endfunction

    assign arb_en = Tick && (state_q == IDLE);

    rr_arbiter #(
        .NrOfReq (NrOfReq),
        .IdxW    (IdxW)
    ) u_rr_arbiter (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // cs/ld are registered from the action of the state being left, so the
    // DRIVE tick produces the settle cycle (cs only), the LATCH tick adds ld,
    // and the RELEASE tick returns the bus to high-Z together with done.
    // This keeps every output a flop with no input-to-output path.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        dst_d   = dst_q;
        grant_d = '0;
        done_d  = 1'b0;
        cs_d    = cs_q;
        ld_d    = ld_q;

        if (Tick) begin
            case (state_q)
                IDLE: begin
                    cs_d = '1;
                    ld_d = '0;
                    if (|arb_gnt) begin
                        grant_d = arb_gnt;
                        src_d   = bus.src[32'(arb_idx) * SelBits +: SelBits];
                        dst_d   = bus.dst[32'(arb_idx) * SelBits +: SelBits];
                        ptr_d   = IdxW'(rr_next(32'(arb_idx), NrOfReq));
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    cs_d    = ~sel_onehot(src_q);
                    ld_d    = '0;
                    state_d = LATCH;
                end
                LATCH: begin
                    cs_d    = ~sel_onehot(src_q);
                    ld_d    = sel_onehot(dst_q);
                    state_d = RELEASE;
                end
                RELEASE: begin
                    cs_d    = '1;
                    ld_d    = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    cs_d    = '1;
                    ld_d    = '0;
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            grant_q <= '0;
            cs_q    <= '1;
            ld_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            grant_q <= grant_d;
            cs_q    <= cs_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.cs    = cs_q;
    assign bus.ld    = ld_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_register_bus_scheduler.sv
// ----------------------------------------------------------------------------
// tb_register_bus_scheduler
// Scoreboard bench: expected grants and transfer results are queued when a
// request is driven and popped when the DUT pulses grant/done. A small
// register-file model follows cs/ld to check the moved data.
// ----------------------------------------------------------------------------
module tb_register_bus_scheduler;

    localparam int unsigned NReq  = 4;
    localparam int unsigned NRegs = 8;
    localparam int unsigned SBits = 4;

    typedef struct {
        int         dst;
        logic [7:0] val;
        logic [7:0] ldmask;
    } xfer_t;

    logic clk;
    logic rst_n = 1'b1;
    logic tick;

    register_bus_scheduler_if #(
        .NrOfReq  (NReq),
        .NrOfRegs (NRegs),
        .SelBits  (SBits)
    ) bus_if ();

    register_bus_scheduler #(
        .NrOfReq  (NReq),
        .NrOfRegs (NRegs),
        .SelBits  (SBits)
    ) dut (
        .Clock (clk),
        .Reset (rst_n),
        .Tick  (tick),
        .bus   (bus_if)
    );

    int    n_checks = 0;
    int    n_err    = 0;
    int    exp_grant_q[$];
    xfer_t exp_xfer_q[$];
    logic  sb_en      = 1'b1;
    logic  spacing_en = 1'b0;

    int         cyc            = 0;
    int         grant_cnt      = 0;
    int         done_cnt       = 0;
    int         last_grant_cyc = -1;
    int         excl_viol      = 0;
    logic [7:0] ld_seen        = '0;

    logic [7:0] regs [NRegs];
    logic       regs_valid = 1'b0;
    logic [7:0] bus_val;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input int s, input int d);
        bus_if.src[i*SBits +: SBits] = SBits'(s);
        bus_if.dst[i*SBits +: SBits] = SBits'(d);
    endtask

    task automatic push_xfer(input int g, input int s, input int d);
        xfer_t x;
        x.dst    = d;
        x.val    = (s < int'(NRegs)) ? regs[s] : 8'h00;
        x.ldmask = (d < int'(NRegs)) ? 8'(1 << d) : 8'h00;
        exp_grant_q.push_back(g);
        exp_xfer_q.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_cs",    bus_if.cs,    8'hFF);
        check("rst_ld",    bus_if.ld,    8'h00);
        check("rst_grant", bus_if.grant, 0);
        check("rst_done",  bus_if.done,  0);
        check("rst_busy",  bus_if.busy,  0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int   start;
        logic ok;
        start = done_cnt;
        ok    = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, ok, 1);
    endtask

    // Register-file model: the single enabled driver puts its value on the
    // bus and every loaded register takes it on a Tick edge.
    always @(posedge clk) begin
        if (!regs_valid) begin
            for (int k = 0; k < int'(NRegs); k++) regs[k] <= 8'hA0 + 8'(k);
            regs_valid <= 1'b1;
        end else if (rst_n && tick) begin
            bus_val = 8'hxx;
            for (int k = 0; k < int'(NRegs); k++) if (!bus_if.cs[k]) bus_val = regs[k];
            for (int k = 0; k < int'(NRegs); k++) if (bus_if.ld[k]) regs[k] <= bus_val;
        end
    end

    // Monitor: bus exclusivity every cycle plus scoreboard pops.
    always @(negedge clk) begin
        int    eg;
        xfer_t x;
        cyc++;
        assert ($countones(~bus_if.cs) <= 1) else excl_viol++;
        assert ($countones(bus_if.ld) <= 1) else excl_viol++;
        assert (bus_if.cs == '1 || bus_if.busy) else excl_viol++;
        assert (bus_if.ld == '0 || bus_if.busy) else excl_viol++;
        if (!spacing_en) last_grant_cyc = -1;
        ld_seen = ld_seen | bus_if.ld;
        if (bus_if.grant != '0) begin
            grant_cnt++;
            ld_seen = '0;
            if (sb_en) begin
                if (exp_grant_q.size() == 0) begin
                    check("grant_unexpected", 32'(bus_if.grant), 0);
                end else begin
                    eg = exp_grant_q.pop_front();
                    check("grant_onehot", 32'(bus_if.grant), 32'(1) << eg);
                end
                if (spacing_en && last_grant_cyc >= 0) check("grant_spacing", cyc - last_grant_cyc, 4);
                last_grant_cyc = cyc;
            end
        end
        if (bus_if.done) begin
            done_cnt++;
            if (sb_en) begin
                if (exp_xfer_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    x = exp_xfer_q.pop_front();
                    check("done_ldmask", ld_seen, x.ldmask);
                    if (x.dst < int'(NRegs)) check("done_data", regs[x.dst], x.val);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        tick = 1'b0;
        bus_if.req = '0;
        bus_if.src = '0;
        bus_if.dst = '0;
        do_reset();

        // Single transfer: requester 0 moves reg 2 into reg 5.
        tick = 1'b1;
        set_slot(0, 2, 5);
        push_xfer(0, 2, 5);
        bus_if.req = 4'b0001;
        step();
        check("t1_grant", bus_if.grant, 4'b0001);
        check("t1_cs_g",  bus_if.cs, 8'hFF);
        check("t1_busy",  bus_if.busy, 1);
        bus_if.req = '0;
        step();
        check("t1_cs_drive", bus_if.cs, 8'hFB);
        check("t1_ld_drive", bus_if.ld, 8'h00);
        step();
        check("t1_cs_latch", bus_if.cs, 8'hFB);
        check("t1_ld_latch", bus_if.ld, 8'h20);
        step();
        check("t1_cs_rel",   bus_if.cs, 8'hFF);
        check("t1_ld_rel",   bus_if.ld, 8'h00);
        check("t1_done",     bus_if.done, 1);
        check("t1_busy_rel", bus_if.busy, 0);
        step();
        check("t1_done_1cyc", bus_if.done, 0);

        // Fairness: all four requesting, grants 0,1,2,3,0 four Ticks apart.
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, i, i + 4);
        for (int i = 0; i < 5; i++) push_xfer(i % 4, i % 4, (i % 4) + 4);
        spacing_en = 1'b1;
        base = grant_cnt;
        bus_if.req = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            step();
            if (grant_cnt - base >= 5) break;
        end
        bus_if.req = '0;
        check("fair_grants", grant_cnt - base, 5);
        wait_done("fair_last", 10);
        spacing_en = 1'b0;

        // Tick gating: requester 2 moves reg 1 into reg 6 with a stalled Tick.
        set_slot(2, 1, 6);
        push_xfer(2, 1, 6);
        bus_if.req = 4'b0100;
        step();
        check("tg_grant", bus_if.grant, 4'b0100);
        bus_if.req = '0;
        tick = 1'b0;
        step();
        check("tg_grant_1cyc", bus_if.grant, 0);
        check("tg_cs_hold0",   bus_if.cs, 8'hFF);
        check("tg_busy_hold",  bus_if.busy, 1);
        tick = 1'b1;
        step();
        check("tg_cs_drive", bus_if.cs, 8'hFD);
        tick = 1'b0;
        step();
        check("tg_cs_hold1", bus_if.cs, 8'hFD);
        step();
        check("tg_cs_hold2", bus_if.cs, 8'hFD);
        check("tg_ld_hold2", bus_if.ld, 8'h00);
        tick = 1'b1;
        step();
        check("tg_ld_latch", bus_if.ld, 8'h40);
        tick = 1'b0;
        step();
        check("tg_cs_hold3", bus_if.cs, 8'hFD);
        check("tg_ld_hold3", bus_if.ld, 8'h40);
        check("tg_done_early", bus_if.done, 0);
        tick = 1'b1;
        step();
        check("tg_done", bus_if.done, 1);
        check("tg_cs_rel", bus_if.cs, 8'hFF);
        tick = 1'b0;
        step();
        check("tg_done_1cyc", bus_if.done, 0);
        check("tg_busy_idle", bus_if.busy, 0);
        tick = 1'b1;

        // Reset mid-transfer: abort requester 0 (reg 3 -> reg 4) while ld is up.
        set_slot(0, 3, 4);
        exp_grant_q.push_back(0);
        bus_if.req = 4'b0001;
        step();
        bus_if.req = '0;
        step();
        check("rm_cs_drive", bus_if.cs, 8'hF7);
        step();
        check("rm_ld_latch", bus_if.ld, 8'h10);
        rst_n = 1'b0;
        #1;
        check("rm_cs_rst", bus_if.cs, 8'hFF);
        check("rm_ld_rst", bus_if.ld, 8'h00);
        check("rm_busy_rst", bus_if.busy, 0);
        set_slot(1, 0, 7);
        push_xfer(1, 0, 7);
        bus_if.req = 4'b0010;
        step();
        check("rm_grant_in_rst0", bus_if.grant, 0);
        step();
        check("rm_grant_in_rst1", bus_if.grant, 0);
        rst_n = 1'b1;
        step();
        check("rm_first_grant", bus_if.grant, 4'b0010);
        bus_if.req = '0;
        wait_done("rm", 8);
        check("rm_noload", regs[4], 8'hA0);

        // src == dst: register 3 reloads itself.
        set_slot(3, 3, 3);
        push_xfer(3, 3, 3);
        bus_if.req = 4'b1000;
        step();
        bus_if.req = '0;
        wait_done("self", 8);

        // Invalid destination: completes with done and no ld.
        set_slot(0, 1, 9);
        push_xfer(0, 1, 9);
        bus_if.req = 4'b0001;
        step();
        bus_if.req = '0;
        wait_done("inval", 8);

        check("sb_grants_left", exp_grant_q.size(), 0);
        check("sb_xfers_left",  exp_xfer_q.size(), 0);

        // Random traffic: only the exclusivity rules are judged here.
        sb_en = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            step();
            bus_if.req = 4'($urandom);
            bus_if.src = 16'($urandom);
            bus_if.dst = 16'($urandom);
            tick = 1'($urandom_range(0, 1));
        end
        bus_if.req = '0;
        tick = 1'b1;
        step();
        check("excl_violations", excl_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
